tt_um_hoene_manchester_encoder: RTL and testbench

TT_UM_HOENE_MANCHESTER_ENCODER -- requirements
Module: tt_um_hoene_manchester_encoder

---
 rtl/tt_um_hoene_pkg.sv | 30 +++
 rtl/tt_um_hoene_bit_fifo.sv | 86 ++++++++
 rtl/tt_um_hoene_manchester_encoder.sv | 164 ++++++++++++++++
 tb/tb_tt_um_hoene_manchester_encoder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tt_um_hoene_pkg.sv
// ---------------------------------------------------------------------------
// tt_um_hoene_pkg
// Shared definitions for the Manchester repeater chain: transmit FSM state
// encoding, half-bit width field size, default minimum half-bit length and
// a helper that clamps a measured half-bit width to that minimum.
// ---------------------------------------------------------------------------
package tt_um_hoene_pkg;

  // Width of the measured half-bit length coming from the decoder.
  localparam int HALFWIDTH_W = 6;

  // Shortest half-bit the encoder will ever drive, in clk cycles.
  localparam int MIN_HALF_DEFAULT = 2;

  // Transmit FSM states.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FIRST_HALF  = 2'd1,
    SECOND_HALF = 2'd2
  } tx_state_e;

  // Clamp a measured half-bit width so it is never shorter than min_half.
  function automatic logic [HALFWIDTH_W-1:0] clamp_half(
    input logic [HALFWIDTH_W-1:0] hw,
    input logic [HALFWIDTH_W-1:0] min_half
  );
    return (hw < min_half) ? min_half : hw;
  endfunction

endpackage

// File: rtl/tt_um_hoene_bit_fifo.sv
// ---------------------------------------------------------------------------
// tt_um_hoene_bit_fifo
// Single-bit-wide FIFO that buffers decoded bits between the decoder and the
// Manchester encoder FSM.
// Ports:
//   clk        system clock (rising edge)
//   rst_n      synchronous active-low reset, empties the buffer
//   flush      synchronous clear, wins over push/pop
//   push       write push_data (ignored when full unless popping this cycle)
//   push_data  bit to store
//   pop        remove the head entry (ignored when empty)
//   pop_data   current head entry, valid while empty is low
//   full       count equals FIFO_DEPTH
//   empty      count equals zero
// ---------------------------------------------------------------------------
module tt_um_hoene_bit_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(1'b0);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          mem_r [FIFO_DEPTH];
  logic          pop_ok_s;
  logic          push_ok_s;

  assign full     = (count_r == DEPTH_C);
  assign empty    = (count_r == CNT_ZERO);
  assign pop_data = mem_r[rd_ptr_r];

  // Qualify requests: a full buffer still accepts a push if it pops too.
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
  end

  // Pointer and occupancy tracking; pointers wrap naturally (power of two).
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 1'b0;
      end
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/tt_um_hoene_manchester_encoder.sv
// ---------------------------------------------------------------------------
// tt_um_hoene_manchester_encoder
// Re-encodes bits recovered by the Manchester decoder and forwards them to
// the next device in the chain. Bits are buffered in a small FIFO and sent
// back-to-back with the half-bit length measured by the decoder.
// Ports:
//   clk           system clock (rising edge)
//   rst_n         synchronous active-low reset
//   in_data       decoded data bit (from the decoder)
//   in_clk        one-cycle strobe marking in_data valid (from the decoder)
//   in_sync       protocol in-sync flag (from insync); low flushes the buffer
//   in_swap       invert forwarded bits (from protocol_select)
//   in_halfwidth  measured half-bit width in clk cycles (decoder pulsewidth)
//   out_line      registered Manchester line: 1 = high-then-low, 0 = low-then-high
//   out_active    high while a bit is on the line
//   out_overflow  sticky: a bit was dropped because the buffer was full
// ---------------------------------------------------------------------------
module tt_um_hoene_manchester_encoder
  import tt_um_hoene_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_HALF   = MIN_HALF_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_data,
  input  logic                   in_clk,
  input  logic                   in_sync,
  input  logic                   in_swap,
  input  logic [HALFWIDTH_W-1:0] in_halfwidth,
  output logic                   out_line,
  output logic                   out_active,
  output logic                   out_overflow
);

  localparam logic [HALFWIDTH_W-1:0] MIN_HALF_C = HALFWIDTH_W'(MIN_HALF);
  localparam logic [HALFWIDTH_W-1:0] HW_ZERO    = HALFWIDTH_W'(1'b0);
  localparam logic [HALFWIDTH_W-1:0] HW_ONE     = HALFWIDTH_W'(1'b1);

  tx_state_e              state_r;
  logic [HALFWIDTH_W-1:0] timer_r;
  logic [HALFWIDTH_W-1:0] h_r;
  logic                   bit_r;
  logic                   out_line_r;
  logic                   out_active_r;
  logic                   overflow_r;

  logic                   push_s;
  logic                   pop_s;
  logic                   drop_s;
  logic                   fifo_data_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [HALFWIDTH_W-1:0] h_sel_s;

  // Losing sync discards everything still waiting in the buffer.
  tt_um_hoene_bit_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (!in_sync),
    .push      (push_s),
    .push_data (in_data ^ in_swap),
    .pop       (pop_s),
    .pop_data  (fifo_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Push/pop/drop decisions; a pop happens only when leaving IDLE or at the
  // last cycle of a second half, and never while out of sync.
  always_comb begin
    push_s  = in_clk && in_sync;
    h_sel_s = clamp_half(in_halfwidth, MIN_HALF_C);
    if (in_sync && !fifo_empty_s) begin
      if (state_r == IDLE) begin
        pop_s = 1'b1;
      end else if ((state_r == SECOND_HALF) && (timer_r == HW_ZERO)) begin
        pop_s = 1'b1;
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      pop_s = 1'b0;
    end
    drop_s = push_s && fifo_full_s && !pop_s;
  end

  // Transmit FSM with half-bit timer and registered line outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      timer_r      <= HW_ZERO;
      h_r          <= HW_ZERO;
      bit_r        <= 1'b0;
      out_line_r   <= 1'b0;
      out_active_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            // H is frozen here until the FSM returns to IDLE.
            h_r          <= h_sel_s;
            timer_r      <= h_sel_s - HW_ONE;
            bit_r        <= fifo_data_s;
            out_line_r   <= fifo_data_s;
            out_active_r <= 1'b1;
            state_r      <= FIRST_HALF;
          end else begin
            out_line_r   <= 1'b0;
            out_active_r <= 1'b0;
          end
        end
        FIRST_HALF: begin
          if (timer_r == HW_ZERO) begin
            timer_r    <= h_r - HW_ONE;
            out_line_r <= ~bit_r;
            state_r    <= SECOND_HALF;
          end else begin
            timer_r <= timer_r - HW_ONE;
          end
        end
        SECOND_HALF: begin
          if (timer_r == HW_ZERO) begin
            if (pop_s) begin
              // Next bit follows with no idle gap.
              timer_r    <= h_r - HW_ONE;
              bit_r      <= fifo_data_s;
              out_line_r <= fifo_data_s;
              state_r    <= FIRST_HALF;
            end else begin
              out_line_r   <= 1'b0;
              out_active_r <= 1'b0;
              state_r      <= IDLE;
            end
          end else begin
            timer_r <= timer_r - HW_ONE;
          end
        end
        default: begin
          timer_r      <= HW_ZERO;
          out_line_r   <= 1'b0;
          out_active_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end
  end

  assign out_line     = out_line_r;
  assign out_active   = out_active_r;
  assign out_overflow = overflow_r;

endmodule

// File: tb/tb_tt_um_hoene_manchester_encoder.sv
// ---------------------------------------------------------------------------
// tb_tt_um_hoene_manchester_encoder
// Directed bench for the Manchester encoder. Each scenario is described by
// two strings indexed by cycle: a stimulus string ('0'/'1' strobe with that
// data bit, 's'/'S' drop/raise in_sync, 'r' pulse reset, '.' nothing) and an
// expected waveform ('.' idle, 'L' active low, 'H' active high).
// ---------------------------------------------------------------------------
module tb_tt_um_hoene_manchester_encoder;

  localparam int NEVER = 100000;

  logic       clk;
  logic       rst_n;
  logic       in_data;
  logic       in_clk;
  logic       in_sync;
  logic       in_swap;
  logic [5:0] in_halfwidth;
  logic       out_line;
  logic       out_active;
  logic       out_overflow;

  int checks;
  int failures;

  tt_um_hoene_manchester_encoder #(
    .FIFO_DEPTH (4),
    .MIN_HALF   (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_clk       (in_clk),
    .in_sync      (in_sync),
    .in_swap      (in_swap),
    .in_halfwidth (in_halfwidth),
    .out_line     (out_line),
    .out_active   (out_active),
    .out_overflow (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a scenario cycle by cycle and compare line/active/overflow.
  task automatic run_vec(input string tag, input int n, input string stim,
                         input string wave, input int ovf_from);
    byte  c;
    logic exp_line;
    logic exp_act;
    logic exp_ovf;
    for (int i = 0; i < n; i++) begin
      c = (i < stim.len()) ? stim[i] : 8'h2e;
      in_clk  = 1'b0;
      in_data = 1'b0;
      case (c)
        8'h30: begin in_clk = 1'b1; in_data = 1'b0; end
        8'h31: begin in_clk = 1'b1; in_data = 1'b1; end
        8'h73: in_sync = 1'b0;
        8'h53: in_sync = 1'b1;
        8'h72: rst_n = 1'b0;
        default: ;
      endcase
      exp_line = (wave[i] == 8'h48);
      exp_act  = (wave[i] != 8'h2e);
      exp_ovf  = (i >= ovf_from);
      checks++;
      assert ({out_line, out_active} === {exp_line, exp_act}) else begin
        failures++;
        $error("FAIL %s cycle %0d line/active got=%b%b exp=%b%b",
               tag, i, out_line, out_active, exp_line, exp_act);
      end
      checks++;
      assert (out_overflow === exp_ovf) else begin
        failures++;
        $error("FAIL %s cycle %0d overflow got=%b exp=%b",
               tag, i, out_overflow, exp_ovf);
      end
      tick();
      rst_n  = 1'b1;
      in_clk = 1'b0;
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    in_data      = 1'b0;
    in_clk       = 1'b0;
    in_sync      = 1'b0;
    in_swap      = 1'b0;
    in_halfwidth = 6'd0;
    tick();
    tick();

    // Reset state.
    checks++;
    assert (out_line === 1'b0) else begin
      failures++;
      $error("FAIL reset_line got=%b exp=0", out_line);
    end
    checks++;
    assert (out_active === 1'b0) else begin
      failures++;
      $error("FAIL reset_active got=%b exp=0", out_active);
    end
    checks++;
    assert (out_overflow === 1'b0) else begin
      failures++;
      $error("FAIL reset_overflow got=%b exp=0", out_overflow);
    end

    rst_n   = 1'b1;
    in_sync = 1'b1;
    tick();

    // Single bit 1, H=5: latency 2, H5 L5, then idle.
    in_halfwidth = 6'd5;
    run_vec("single_bit", 13, "1", "..HHHHHLLLLL.", NEVER);

    // Bits 0,1,1 every 3 cycles, H=4: continuous 24-cycle waveform.
    in_halfwidth = 6'd4;
    run_vec("three_bits", 27, "0..1..1",
            "..LLLLHHHHHHHHLLLLHHHHLLLL.", NEVER);

    // Swap inverts bit 1 to 0; halfwidth 1 clamps to H=2.
    in_swap      = 1'b1;
    in_halfwidth = 6'd1;
    run_vec("swap_minhalf", 7, "1", "..LLHH.", NEVER);
    in_swap = 1'b0;

    // Push arrives on the last cycle of a second half with an empty buffer:
    // FSM idles one cycle, then sends the stored bit.
    in_halfwidth = 6'd2;
    run_vec("late_push", 12, "1....0", "..HHLL.LLHH.", NEVER);

    // Six back-to-back strobes into depth 4 with H=8: five bits sent,
    // sixth dropped, overflow visible from cycle 6 onward.
    in_halfwidth = 6'd8;
    run_vec("overflow", 83, "101101",
            "..HHHHHHHHLLLLLLLLLLLLLLLLHHHHHHHHHHHHHHHHLLLLLLLLHHHHHHHHLLLLLLLLLLLLLLLLHHHHHHHH.",
            6);

    // Sync drops in the first half of bit 2: bit 2 completes, 3 and 4 are
    // flushed; a strobe while out of sync is ignored.
    in_halfwidth = 6'd3;
    run_vec("sync_drop", 20, "1010.....s..1",
            "..HHHLLLLLLHHH......", 0);

    // Reset during the second half aborts the bit and clears overflow.
    in_sync      = 1'b1;
    in_halfwidth = 6'd4;
    run_vec("reset_mid_a", 8, "1......r", "..HHHHLL", 0);
    run_vec("reset_mid_b", 12, ".1", "...HHHHLLLL.", NEVER);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
